// File: rtl/ibuffer.sv
// rtl/ibuffer.sv - instruction buffer between fetch and decode
//
// config_pkg : shared core configuration (address width, instruction width, fetch width).
// ibuffer    : circular FIFO holding one instruction per entry with its PC and predicted next-PC.
//   clk, rst         clock, synchronous active-high reset
//   fe_valid_i       fetch group valid
//   fe_ready_o       room for a full fetch group
//   fe_pc_i          PC of slot 0
//   fe_data_i        instruction per slot
//   fe_slot_valid_i  prefix mask of valid slots
//   fe_pred_npc_i    predicted next PC per slot
//   de_valid_o       prefix mask of valid decode lanes
//   de_instr_o       instruction per lane, lane 0 oldest
//   de_pc_o          PC per lane
//   de_pred_npc_o    predicted next PC per lane
//   de_ready_i       decode takes every valid lane this cycle
//   flush_i          backend flush, empties the buffer

package config_pkg;
  typedef struct packed {
    int unsigned PLEN;
    int unsigned ILEN;
    int unsigned INSTR_PER_FETCH;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{PLEN: 32, ILEN: 32, INSTR_PER_FETCH: 4};
endpackage

module ibuffer #(
  parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DEC_W = 4,
  localparam int unsigned PLEN = Cfg.PLEN,
  localparam int unsigned ILEN = Cfg.ILEN,
  localparam int unsigned IPF  = Cfg.INSTR_PER_FETCH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fe_valid_i,
  output logic                    fe_ready_o,
  input  logic [PLEN-1:0]         fe_pc_i,
  input  logic [IPF*ILEN-1:0]     fe_data_i,
  input  logic [IPF-1:0]          fe_slot_valid_i,
  input  logic [IPF*PLEN-1:0]     fe_pred_npc_i,
  output logic [DEC_W-1:0]        de_valid_o,
  output logic [DEC_W*ILEN-1:0]   de_instr_o,
  output logic [DEC_W*PLEN-1:0]   de_pc_o,
  output logic [DEC_W*PLEN-1:0]   de_pred_npc_o,
  input  logic                    de_ready_i,
  input  logic                    flush_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [PLEN-1:0] pc_mem    [DEPTH];
  logic [PLEN-1:0] npc_mem   [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [CW-1:0] n_enq;
  logic [CW-1:0] k_deq;
  logic          enq, deq;

  // Ready depends only on registered occupancy, so once raised it can only be
  // lowered by an enqueue; fetch samples it at request time and relies on that.
  assign fe_ready_o = (count_q <= CW'(DEPTH - IPF));

  assign enq = fe_valid_i & fe_ready_o & ~flush_i;
  assign deq = de_ready_i & (count_q != '0) & ~flush_i;

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < int'(IPF); i++) begin
      n_enq = n_enq + CW'(fe_slot_valid_i[i]);
    end
  end

  assign k_deq = (count_q < CW'(DEC_W)) ? count_q : CW'(DEC_W);

  // Decode lanes read straight from storage at the registered read pointer;
  // lanes past the occupancy are forced to zero.
  always_comb begin
    logic [PW-1:0] idx;
    de_valid_o    = '0;
    de_instr_o    = '0;
    de_pc_o       = '0;
    de_pred_npc_o = '0;
    for (int j = 0; j < int'(DEC_W); j++) begin
      idx = rd_ptr_q + PW'(j);
      if (CW'(j) < count_q) begin
        de_valid_o[j]                   = 1'b1;
        de_instr_o[j*ILEN +: ILEN]      = instr_mem[idx];
        de_pc_o[j*PLEN +: PLEN]         = pc_mem[idx];
        de_pred_npc_o[j*PLEN +: PLEN]   = npc_mem[idx];
      end
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(IPF); i++) begin
      if (enq && fe_slot_valid_i[i]) begin
        instr_mem[wr_ptr_q + PW'(i)] <= fe_data_i[i*ILEN +: ILEN];
        pc_mem[wr_ptr_q + PW'(i)]    <= fe_pc_i + PLEN'(4 * i);
        npc_mem[wr_ptr_q + PW'(i)]   <= fe_pred_npc_i[i*PLEN +: PLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(n_enq);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(k_deq);
      count_q <= count_q + (enq ? n_enq : '0) - (deq ? k_deq : '0);
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  // A prefix mask plus one is a power of two (or wraps to zero).
  a_slot_prefix : assert property (@(posedge clk) disable iff (rst)
    fe_valid_i |-> ((fe_slot_valid_i & (fe_slot_valid_i + IPF'(1))) == '0));

endmodule
